// File: rtl/endstop_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : endstop_conditioner_pkg
// Description : Shared endstop constants and types. The channel count and
//               counter width defaults are consumed by the conditioner and by
//               the endstop mux that sits downstream of it.
// Revision    : 1.0 - initial release
// ============================================================================
package endstop_conditioner_pkg;

    // Default number of endstop channels.
    localparam int c_endstop_nch   = 8;
    // Default debounce counter / threshold width in bits.
    localparam int c_endstop_cnt_w = 16;

    // Per-channel debounce action decoded each cycle.
    localparam logic [1:0] c_act_idle   = 2'd0; // sync agrees with signal
    localparam logic [1:0] c_act_count  = 2'd1; // disagreement, below threshold
    localparam logic [1:0] c_act_accept = 2'd2; // disagreement reached threshold

endpackage : endstop_conditioner_pkg
`default_nettype wire

// File: rtl/endstop_debounce.sv
`default_nettype none
// ============================================================================
// Module      : endstop_debounce
// Description : One endstop channel: 2-flop synchronizer, stable-cycle
//               debounce counter, armed rising-edge strobe and sticky hold.
// Ports       : clk, rst_n        - clock, async active-low reset
//               raw               - unsynchronized endstop pin
//               thr               - effective threshold (already >= 1)
//               arm               - enables strobe/hold generation
//               clear_hold        - single-cycle hold clear
//               signal, stb, hold - registered debounced level, strobe, flag
// Revision    : 1.0 - initial release
// ============================================================================
module endstop_debounce
    import endstop_conditioner_pkg::*;
#(
    parameter int CNT_W = c_endstop_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw,
    input  logic [CNT_W-1:0] thr,
    input  logic             arm,
    input  logic             clear_hold,
    output logic             signal,
    output logic             stb,
    output logic             hold
);

    logic             r_sync_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_signal;
    logic             r_stb;
    logic             r_hold;

    logic [CNT_W:0]   w_cnt_inc;
    logic [1:0]       w_action;
    logic             w_stb_next;

    // The increment is one bit wider so the threshold compare can never be
    // fooled by a wrap; the counter itself only advances while below thr,
    // so it never reaches the top of its range.
    always_comb begin
        w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
        w_action  = c_act_idle;
        if (r_sync != r_signal) begin
            if (w_cnt_inc >= {1'b0, thr}) begin
                w_action = c_act_accept;
            end else begin
                w_action = c_act_count;
            end
        end
    end

    // Strobe only on an accepted 0->1 change, qualified by arm in that cycle.
    always_comb begin
        w_stb_next = (w_action == c_act_accept) && r_sync && arm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_cnt       <= '0;
            r_signal    <= 1'b0;
            r_stb       <= 1'b0;
            r_hold      <= 1'b0;
        end else begin
            r_sync_meta <= raw;
            r_sync      <= r_sync_meta;
            case (w_action)
                c_act_count: begin
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                end
                c_act_accept: begin
                    r_cnt    <= '0;
                    r_signal <= r_sync;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
            r_stb  <= w_stb_next;
            // Set has priority over a coincident clear.
            r_hold <= w_stb_next | (r_hold & ~clear_hold);
        end
    end

    assign signal = r_signal;
    assign stb    = r_stb;
    assign hold   = r_hold;

endmodule : endstop_debounce
`default_nettype wire

// File: rtl/endstop_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : endstop_conditioner
// Description : NCH independent endstop channels, each synchronized,
//               debounced against a shared threshold, with armed strobe and
//               sticky hold outputs. All outputs are registered.
// Ports       : clk, rst_n     - clock, async active-low reset
//               raw            - [NCH] unsynchronized endstop pins
//               debounce_cycles- [CNT_W] stable-cycles threshold (0 acts as 1)
//               arm            - [NCH] strobe/hold enables
//               clear_holds    - [NCH] hold clears
//               signals        - [NCH] debounced levels
//               stbs           - [NCH] one-cycle rising strobes
//               holds          - [NCH] latched trigger flags
// Revision    : 1.0 - initial release
// ============================================================================
module endstop_conditioner
    import endstop_conditioner_pkg::*;
#(
    parameter int NCH   = c_endstop_nch,
    parameter int CNT_W = c_endstop_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   raw,
    input  logic [CNT_W-1:0] debounce_cycles,
    input  logic [NCH-1:0]   arm,
    input  logic [NCH-1:0]   clear_holds,
    output logic [NCH-1:0]   signals,
    output logic [NCH-1:0]   stbs,
    output logic [NCH-1:0]   holds
);

    logic [CNT_W-1:0] w_thr;

    // A zero threshold behaves as one so a change is still seen for a cycle.
    always_comb begin
        w_thr = debounce_cycles;
        if (debounce_cycles == '0) begin
            w_thr = {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            endstop_debounce #(
                .CNT_W (CNT_W)
            ) u_debounce (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw        (raw[gi]),
                .thr        (w_thr),
                .arm        (arm[gi]),
                .clear_hold (clear_holds[gi]),
                .signal     (signals[gi]),
                .stb        (stbs[gi]),
                .hold       (holds[gi])
            );
        end
    endgenerate

endmodule : endstop_conditioner
`default_nettype wire

// File: tb/tb_endstop_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_endstop_conditioner
// Description : Scoreboard bench for endstop_conditioner. A driver issues
//               inputs on the falling edge and pushes the reference model's
//               expected outputs; a monitor pops and compares after each
//               rising edge. Directed scenarios add explicit timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_endstop_conditioner;

    localparam int NCH   = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   raw;
    logic [CNT_W-1:0] debounce_cycles;
    logic [NCH-1:0]   arm;
    logic [NCH-1:0]   clear_holds;
    logic [NCH-1:0]   signals;
    logic [NCH-1:0]   stbs;
    logic [NCH-1:0]   holds;

    endstop_conditioner #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .raw             (raw),
        .debounce_cycles (debounce_cycles),
        .arm             (arm),
        .clear_holds     (clear_holds),
        .signals         (signals),
        .stbs            (stbs),
        .holds           (holds)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] sig;
        logic [NCH-1:0] stb;
        logic [NCH-1:0] hold;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: pin history pipeline and length of the current run
    // of samples that disagree with the accepted level.
    logic [NCH-1:0] m_pipe1, m_pipe2, m_sig, m_stb, m_hold;
    int             m_run[NCH];

    task automatic check_vec(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe1 = '0; m_pipe2 = '0; m_sig = '0; m_stb = '0; m_hold = '0;
        for (int i = 0; i < NCH; i++) m_run[i] = 0;
    endtask

    task automatic model_edge(input logic [NCH-1:0] r, input logic [CNT_W-1:0] dc,
                              input logic [NCH-1:0] a, input logic [NCH-1:0] c);
        int thr;
        thr = (dc == 0) ? 1 : int'(dc);
        for (int i = 0; i < NCH; i++) begin
            m_stb[i] = 1'b0;
            if (m_pipe2[i] == m_sig[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] + 1 >= thr) begin
                m_sig[i] = m_pipe2[i];
                m_run[i] = 0;
                m_stb[i] = m_pipe2[i] & a[i];
            end else begin
                m_run[i] = m_run[i] + 1;
            end
            m_hold[i] = m_stb[i] | (m_hold[i] & ~c[i]);
        end
        m_pipe2 = m_pipe1;
        m_pipe1 = r;
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic step(input logic [NCH-1:0] r, input logic [CNT_W-1:0] dc,
                        input logic [NCH-1:0] a, input logic [NCH-1:0] c, input logic rs);
        exp_t e;
        @(negedge clk);
        raw = r; debounce_cycles = dc; arm = a; clear_holds = c; rst_n = rs;
        if (!rs) begin
            model_reset();
            #1;
            check_vec("reset_signals", signals, '0);
            check_vec("reset_stbs", stbs, '0);
            check_vec("reset_holds", holds, '0);
        end else begin
            model_edge(r, dc, a, c);
        end
        e.sig = m_sig; e.stb = m_stb; e.hold = m_hold;
        q.push_back(e);
    endtask

    task automatic do_reset(input logic [NCH-1:0] r, input logic [CNT_W-1:0] dc);
        repeat (2) step(r, dc, '1, '0, 1'b0);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are valid every cycle; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_vec("sb_signals", signals, e.sig);
                check_vec("sb_stbs", stbs, e.stb);
                check_vec("sb_holds", holds, e.hold);
            end
        end
    end

    initial begin
        logic [NCH-1:0]   cr, ca, cc;
        logic [CNT_W-1:0] cdc;
        logic             crs;

        rst_n = 1'b0; raw = '0; debounce_cycles = 16'd4; arm = '1; clear_holds = '0;
        model_reset();

        // Clean rising edge, thr=4: level after 6 edges, single strobe, hold.
        do_reset('0, 16'd4);
        for (int k = 1; k <= 8; k++) begin
            step(8'h01, 16'd4, 8'hFF, 8'h00, 1'b1);
            sample();
            check_bit("thr4_signal0", signals[0], k >= 6);
            check_bit("thr4_stb0", stbs[0], k == 6);
            check_bit("thr4_hold0", holds[0], k >= 6);
        end

        // Three-cycle glitch with thr=4 never reaches the output.
        do_reset('0, 16'd4);
        for (int k = 1; k <= 9; k++) begin
            step((k <= 3) ? 8'h08 : 8'h00, 16'd4, 8'hFF, 8'h00, 1'b1);
            sample();
            check_bit("glitch_signal3", signals[3], 1'b0);
            check_bit("glitch_hold3", holds[3], 1'b0);
        end

        // Zero threshold behaves as one: level after 3 edges.
        do_reset('0, 16'd0);
        for (int k = 1; k <= 4; k++) begin
            step(8'h20, 16'd0, 8'hFF, 8'h00, 1'b1);
            sample();
            check_bit("thr0_signal5", signals[5], k >= 3);
        end

        // Disarmed channel follows the pin without strobe/hold; re-armed does.
        do_reset('0, 16'd2);
        repeat (6) step(8'h04, 16'd2, 8'hFB, 8'h00, 1'b1);
        sample();
        check_bit("disarm_signal2", signals[2], 1'b1);
        check_bit("disarm_hold2", holds[2], 1'b0);
        repeat (6) step(8'h00, 16'd2, 8'hFF, 8'h00, 1'b1);
        repeat (6) step(8'h04, 16'd2, 8'hFF, 8'h00, 1'b1);
        sample();
        check_bit("rearm_hold2", holds[2], 1'b1);

        // Clear coinciding with the strobe loses; a later lone clear wins.
        do_reset('0, 16'd2);
        for (int k = 1; k <= 4; k++) begin
            step(8'h02, 16'd2, 8'hFF, (k == 4) ? 8'h02 : 8'h00, 1'b1);
            sample();
            check_bit("setwins_stb1", stbs[1], k == 4);
            check_bit("setwins_hold1", holds[1], k >= 4);
        end
        step(8'h02, 16'd2, 8'hFF, 8'h00, 1'b1);
        sample();
        check_bit("hold1_kept", holds[1], 1'b1);
        step(8'h02, 16'd2, 8'hFF, 8'h02, 1'b1);
        sample();
        check_bit("hold1_cleared", holds[1], 1'b0);

        // Pins high through reset debounce after release and strobe.
        repeat (3) step(8'hFF, 16'd2, 8'hFF, 8'h00, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(8'hFF, 16'd2, 8'hFF, 8'h00, 1'b1);
            sample();
            check_vec("thr_release_signals", signals, (k >= 4) ? 8'hFF : 8'h00);
            check_vec("thr_release_stbs", stbs, (k == 4) ? 8'hFF : 8'h00);
        end
        // Reset mid-count then release with pins still low: nothing happens.
        repeat (2) step(8'h00, 16'd4, 8'hFF, 8'h00, 1'b1);
        step(8'h00, 16'd4, 8'hFF, 8'h00, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(8'h00, 16'd4, 8'hFF, 8'h00, 1'b1);
            sample();
            check_vec("midreset_signals", signals, 8'h00);
            check_vec("midreset_stbs", stbs, 8'h00);
        end

        // Randomized traffic against the reference model.
        cr = '0; cdc = 16'd3; ca = '1; cc = '0; crs = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 7) == 0) cr[i] = ~cr[i];
                cc[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 199) == 0) cdc = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) ca = NCH'($urandom);
            crs = ($urandom_range(0, 499) != 0);
            step(cr, cdc, ca, cc, crs);
        end
        step(cr, cdc, ca, 8'h00, 1'b1);

        // Every queued expectation must have been consumed by the monitor.
        repeat (3) sample();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_endstop_conditioner
`default_nettype wire
